video_compositor: RTL

Parametrised, registered layer compositor for the VGA pixel path. It replaces the fixed six-input combinational priority mux.
- Takes NUM_LAYERS colour layers plus a background and selects the visible pixel by fixed priority (index 0 highest).
- Adds per-layer enable and flash masks, shadowed so they update on frame boundaries.
- Adds per-frame sticky overlap (collision) flags for game logic.
- Sits between the sprite/object generators and the RGB output pins.

---
 rtl/video_compositor_pkg.sv | 18 +
 rtl/video_compositor_if.sv | 30 +++
 rtl/video_compositor_prio_select.sv | 24 ++
 rtl/video_compositor.sv | 114 +++++++++++
 4 files changed

// File: rtl/video_compositor_pkg.sv
// Shared constants for the VGA layer compositor: default widths, blank colour
// and the fixed layer assignment used by the game's pixel path.
package video_compositor_pkg;

  localparam int NUM_LAYERS_DEF  = 5;
  localparam int COLOR_W_DEF     = 6;
  localparam int FLASH_DIV_DEF   = 5;
  localparam int BLANK_COLOR_DEF = 0;

  typedef enum logic [2:0] {
    BORDER = 3'd0,
    PADDLE = 3'd1,
    BLOCKS = 3'd2,
    BALL   = 3'd3,
    LIVES  = 3'd4
  } layer_idx_e;

endpackage

// File: rtl/video_compositor_if.sv
// Pixel-path bundle between the object generators (master) and the compositor
// (slave): layer inputs, config masks and the registered composited outputs.
interface video_compositor_if #(
  parameter int NUM_LAYERS = 5,
  parameter int COLOR_W    = 6
);
  logic                          in_frame;
  logic                          frame_start;
  logic [COLOR_W-1:0]            background;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
  logic [NUM_LAYERS-1:0]         layer_en;
  logic                          cfg_we;
  logic [NUM_LAYERS-1:0]         cfg_layer_mask;
  logic [NUM_LAYERS-1:0]         cfg_flash_mask;
  logic [COLOR_W-1:0]            out;
  logic                          out_valid;
  logic [NUM_LAYERS-1:0]         collision;

  modport master (
    output in_frame, frame_start, background, layer_color, layer_en,
           cfg_we, cfg_layer_mask, cfg_flash_mask,
    input  out, out_valid, collision
  );

  modport slave (
    input  in_frame, frame_start, background, layer_color, layer_en,
           cfg_we, cfg_layer_mask, cfg_flash_mask,
    output out, out_valid, collision
  );
endinterface

// File: rtl/video_compositor_prio_select.sv
// Combinational lowest-index-wins priority encoder; reports whether any request
// is set and the index of the winning one.
module prio_select #(
  parameter  int N     = 5,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/video_compositor.sv
// Two-stage registered layer compositor with frame-shadowed enable/flash masks
// and per-frame sticky layer-overlap flags.
module video_compositor
  import video_compositor_pkg::*;
#(
  parameter int                 NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int                 COLOR_W     = COLOR_W_DEF,
  parameter logic [COLOR_W-1:0] BLANK_COLOR = COLOR_W'(BLANK_COLOR_DEF),
  parameter int                 FLASH_DIV   = FLASH_DIV_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  video_compositor_if.slave  vid
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef logic [NUM_LAYERS-1:0] mask_t;

  mask_t                pend_mask_q,  pend_mask_d;
  mask_t                act_mask_q,   act_mask_d;
  mask_t                pend_flash_q, pend_flash_d;
  mask_t                act_flash_q,  act_flash_d;
  logic [FLASH_DIV-1:0] frame_cnt_q,  frame_cnt_d;
  logic                 flash_phase;
  mask_t                eff;

  mask_t                eff_q;
  logic [COLOR_W-1:0]   col_q [NUM_LAYERS];
  logic [COLOR_W-1:0]   bg_q;
  logic                 in_frame_q;

  logic                 sel_hit;
  logic [IDX_W-1:0]     sel_idx;
  logic [COLOR_W-1:0]   out_q, out_d;
  logic                 out_valid_q;

  mask_t                acc_q, acc_d;
  mask_t                coll_q, coll_d;
  logic                 multi_hit;
  mask_t                new_hits;

  // A write coinciding with frame_start bypasses pending and lands in active.
  always_comb begin
    pend_mask_d  = vid.cfg_we ? vid.cfg_layer_mask : pend_mask_q;
    pend_flash_d = vid.cfg_we ? vid.cfg_flash_mask : pend_flash_q;
    act_mask_d   = vid.frame_start ? pend_mask_d  : act_mask_q;
    act_flash_d  = vid.frame_start ? pend_flash_d : act_flash_q;
    frame_cnt_d  = vid.frame_start ? frame_cnt_q + FLASH_DIV'(1) : frame_cnt_q;
    flash_phase  = frame_cnt_d[FLASH_DIV-1];
    eff          = vid.layer_en & act_mask_d & ~(act_flash_d & {NUM_LAYERS{flash_phase}});
  end

  prio_select #(.N(NUM_LAYERS)) u_prio (
    .req_i (eff_q),
    .hit_o (sel_hit),
    .idx_o (sel_idx)
  );

  always_comb begin
    out_d = BLANK_COLOR;
    if (in_frame_q) out_d = sel_hit ? col_q[sel_idx] : bg_q;
  end

  // Overlap pixels seen on the frame_start cycle belong to the new frame.
  always_comb begin
    multi_hit = in_frame_q && ((eff_q & (eff_q - mask_t'(1))) != '0);
    new_hits  = multi_hit ? eff_q : '0;
    if (vid.frame_start) begin
      coll_d = acc_q;
      acc_d  = new_hits;
    end else begin
      coll_d = coll_q;
      acc_d  = acc_q | new_hits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mask_q  <= '1;
      act_mask_q   <= '1;
      pend_flash_q <= '0;
      act_flash_q  <= '0;
      frame_cnt_q  <= '0;
      eff_q        <= '0;
      bg_q         <= '0;
      in_frame_q   <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) col_q[i] <= '0;
      out_q        <= BLANK_COLOR;
      out_valid_q  <= 1'b0;
      acc_q        <= '0;
      coll_q       <= '0;
    end else begin
      pend_mask_q  <= pend_mask_d;
      act_mask_q   <= act_mask_d;
      pend_flash_q <= pend_flash_d;
      act_flash_q  <= act_flash_d;
      frame_cnt_q  <= frame_cnt_d;
      eff_q        <= eff;
      bg_q         <= vid.background;
      in_frame_q   <= vid.in_frame;
      for (int i = 0; i < NUM_LAYERS; i++) col_q[i] <= vid.layer_color[i*COLOR_W +: COLOR_W];
      out_q        <= out_d;
      out_valid_q  <= in_frame_q;
      acc_q        <= acc_d;
      coll_q       <= coll_d;
    end
  end

  assign vid.out       = out_q;
  assign vid.out_valid = out_valid_q;
  assign vid.collision = coll_q;

endmodule
